// File: rtl/shift_sequencer.sv
// Control stage for the downstream shiftreg: buffers one parallel word, strobes
// its load, then paces WIDTH shift strobes at a programmable bit period.
module shift_sequencer #(
  parameter int WIDTH     = 10,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clock_in,
  input  logic                 reset_in,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  input  logic [DIV_WIDTH-1:0] divisor_in,
  output logic                 load_out,
  output logic                 shift_out,
  output logic [WIDTH-1:0]     data_out,
  output logic                 word_done_out,
  output logic                 busy_out
);

  localparam int BITS_W = $clog2(WIDTH + 1);
  localparam logic [BITS_W-1:0] LAST_BIT = BITS_W'(WIDTH - 1);
  localparam logic [BITS_W-1:0] PENULT_BIT = BITS_W'(WIDTH - 2);
  localparam logic [BITS_W-1:0] BIT_ONE = BITS_W'(1);
  localparam logic [DIV_WIDTH-1:0] CNT_ONE = DIV_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  state_t               state;
  logic                 hold_full;
  logic [WIDTH-1:0]     hold_data;
  logic [DIV_WIDTH-1:0] div_reg;
  logic [DIV_WIDTH-1:0] cnt;
  logic [BITS_W-1:0]    bits;
  logic                 accept;

  assign ready_out = !hold_full;
  assign busy_out  = (state != IDLE) || hold_full;
  assign accept    = valid_in && !hold_full;

  // Strobes are registered, so each one is decided an edge early from what
  // the counters will hold in the cycle where it must appear.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state         <= IDLE;
      hold_full     <= 1'b0;
      hold_data     <= '0;
      div_reg       <= '0;
      cnt           <= '0;
      bits          <= '0;
      load_out      <= 1'b0;
      shift_out     <= 1'b0;
      word_done_out <= 1'b0;
      data_out      <= '0;
    end else begin
      load_out      <= 1'b0;
      shift_out     <= 1'b0;
      word_done_out <= 1'b0;

      if (accept) begin
        hold_full <= 1'b1;
        hold_data <= data_in;
      end

      case (state)
        IDLE: begin
          if (hold_full) begin
            state     <= LOAD;
            load_out  <= 1'b1;
            data_out  <= hold_data;
            hold_full <= 1'b0;
          end
        end

        LOAD: begin
          div_reg <= divisor_in;
          cnt     <= divisor_in;
          bits    <= '0;
          state   <= SHIFT;
          if (divisor_in == '0) begin
            shift_out     <= 1'b1;
            word_done_out <= (WIDTH == 1);
          end
        end

        SHIFT: begin
          if (cnt == '0) begin
            bits <= bits + BIT_ONE;
            cnt  <= div_reg;
            if (bits == LAST_BIT) begin
              // Chain straight into the next word when one is already waiting.
              if (hold_full) begin
                state     <= LOAD;
                load_out  <= 1'b1;
                data_out  <= hold_data;
                hold_full <= 1'b0;
              end else begin
                state <= IDLE;
              end
            end else if (div_reg == '0) begin
              shift_out     <= 1'b1;
              word_done_out <= (bits == PENULT_BIT);
            end
          end else begin
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
              shift_out     <= 1'b1;
              word_done_out <= (bits == LAST_BIT);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Upstream control stage for the `shiftreg` block. Accepts parallel words over a valid/ready handshake into a one-entry holding buffer. Drives the shift register's parallel load, then issues WIDTH evenly spaced shift strobes at a programmable bit rate. Signals per-word completion, and streams back-to-back words with no idle cycle between them when the holding buffer is refilled in time.

## Interface
- `WIDTH`, default 10: word width in bits; equals the WIDTH of the downstream shiftreg.
- `DIV_WIDTH`, default 16: width of the bit-period divisor.
- `clock_in`  input  1  sole clock; all state updates on the rising edge.
- `reset_in`  input  1  asynchronous, active-high reset.
- `data_in`  input  WIDTH  word to transmit; sampled on accept.
- `valid_in`  input  1  upstream has a word on `data_in`.
- `ready_out`  output  1  holding buffer empty; a word is accepted on any edge where `valid_in & ready_out`.
- `divisor_in`  input  DIV_WIDTH  bit period minus one, in clocks; sampled only in LOAD.
- `load_out`  output  1  one-cycle parallel-load strobe to shiftreg `load_in`.
- `shift_out`  output  1  one-cycle shift strobe to shiftreg `shift_in`.
- `data_out`  output  WIDTH  word presented to shiftreg `data_in`; valid during `load_out` and held until the next load.
- `word_done_out`  output  1  one-cycle pulse coincident with the WIDTH-th `shift_out` of a word.
- `busy_out`  output  1  high when not in IDLE or when the holding buffer is full.

## Operation
- Holding buffer: one entry, `hold_data` and `hold_full`.
  - `ready_out = !hold_full`, with no bypass.
  - Accept sets `hold_full`. Transition to LOAD clears it.
  - Accept and drain never coincide.
- States:
  - IDLE: if `hold_full`, go to LOAD.
  - LOAD: `load_out`=1 and `data_out`<=`hold_data`. Latch `div_reg`<=`divisor_in`, `cnt`<=`divisor_in`, `bits`<=0. Next state is SHIFT.
  - SHIFT: each cycle, if `cnt`==0, pulse `shift_out` and set `bits`<=`bits`+1, `cnt`<=`div_reg`; otherwise `cnt`<=`cnt`-1.
    - On the shift where `bits`==WIDTH-1, `word_done_out`=1.
    - After that shift, go to LOAD if `hold_full`, else IDLE.
- `bits` is sized to hold values up to WIDTH. `cnt` and `div_reg` are DIV_WIDTH bits, unsigned, with no wrap: reload occurs at zero.
- `divisor_in`=0 gives one shift per clock. Maximum divisor gives 2^DIV_WIDTH clocks per bit.
- A change of `divisor_in` mid-word has no effect until the next LOAD.
- All strobe and data outputs are registered. `ready_out` and `busy_out` are decoded from registers.
- Reset values, applied asynchronously while `reset_in`=1:
  - state IDLE, `hold_full`=0, `ready_out`=1;
  - `load_out`=0, `shift_out`=0, `word_done_out`=0, `busy_out`=0;
  - `data_out`=0, `cnt`=0, `bits`=0.
  - No accept occurs while reset is asserted.
- Reset mid-word or with the buffer full: the in-flight and held words are discarded. No further strobes or `word_done_out` are produced for them.

## Timing
- Word accepted on edge E0. `ready_out` falls after E0.
- IDLE sees `hold_full` and transitions at E1. `load_out` is high in cycle L (after E1), and `ready_out` is high again in cycle L.
- With divisor D, `shift_out` is high in cycles L+k(D+1) for k=1..WIDTH. `word_done_out` is high in cycle L+WIDTH(D+1).
- Latency from accept to first shift: 2+(D+1) edges. Word period: 1+WIDTH(D+1) cycles.
- Back-to-back: if the next word is accepted by the edge ending cycle L+WIDTH(D+1), its `load_out` is in cycle L+WIDTH(D+1)+1. There is no gap cycle.
- `load_out` and `shift_out` are never high in the same cycle.

## Test plan
- Reset then idle, with `valid_in`=0 -> all outputs at reset values, `ready_out`=1, `busy_out`=0, for 20 cycles.
- One word 10'h2A5 with D=0 -> `load_out` 1 cycle with `data_out`=10'h2A5; 10 consecutive `shift_out` cycles; `word_done_out` on the 10th; back to IDLE, `busy_out`=0.
- One word with D=3 -> `shift_out` spacing exactly 4 cycles, first pulse 4 cycles after `load_out`, 10 pulses total. Changing `divisor_in` to 7 mid-word leaves the spacing at 4.
- Three words with `valid_in` held high and D=1 -> loads exactly 21 cycles apart. `ready_out` drops for 1 accept per word. No cycle has both `load_out` and `shift_out`. Data order preserved.
- `valid_in` high while the buffer is full -> no accept (`ready_out`=0), and `data_in` changes are ignored until `ready_out` rises.
- Assert `reset_in` after the 5th shift with the buffer full -> immediate reset values, no further `shift_out` or `word_done_out`. After release, a new word sequences normally.
